// File: rtl/addsub_serial_nbit.sv
// addsub_serial_nbit
//   Digit-serial N-bit adder/subtractor. Each clock adds one DIGIT-wide slice
//   of the operands, least significant slice first. The carry between slices
//   is kept in a register. A start/busy/done handshake frames each operation.
//   Alongside the result it reports the carry (add) or true borrow (sub),
//   signed overflow and zero.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per clock (1..WIDTH, WIDTH % DIGIT == 0)
//
// Ports
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset
//   start             request an operation; accepted only while busy == 0
//   a, b              operands, sampled on accept
//   sel_add1_sub0     1: a+b, 0: a-b, sampled on accept
//   busy              high while digits are being processed
//   done              one-cycle pulse when the result registers update
//   sum_diff          result modulo 2^WIDTH, held until the next done
//   carry_borrow_out  add: carry out of MSB; sub: 1 iff unsigned a < b
//   overflow          signed overflow of the selected operation
//   zero              sum_diff == 0
module addsub_serial_nbit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel_add1_sub0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_diff,
  output logic             carry_borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             last_s;

  // Operand shift registers: the current digit always sits in the low bits.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             sub_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT-1:0] dig_sum_s;
  logic             dig_cout_s;
  logic [WIDTH-1:0] res_nxt_s;
  logic             ovf_s;

  // One digit of ripple addition, returning {carry_out, sum}.
  function automatic logic [DIGIT:0] digit_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             cin
  );
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  endfunction

  // Next-state decode and handshake events.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = ST_DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Digit adder and assembly of the full result including the current digit.
  // The carry into the MSB equals r_msb ^ a_msb ^ b'_msb, so overflow needs
  // no separate sub-digit adder regardless of DIGIT.
  always_comb begin
    {dig_cout_s, dig_sum_s} = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
    res_nxt_s = (res_r >> DIGIT) | (WIDTH'(dig_sum_s) << (WIDTH - DIGIT));
    ovf_s     = dig_sum_s[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dig_cout_s;
  end

  // State register plus registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == ST_RUN);
      done    <= last_s;
    end
  end

  // Operand capture on accept, then one digit per edge while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      a_r     <= a;
      b_r     <= sel_add1_sub0 ? b : ~b;
      carry_r <= ~sel_add1_sub0;
      sub_r   <= ~sel_add1_sub0;
      cnt_r   <= {CW{1'b0}};
      res_r   <= {WIDTH{1'b0}};
    end else if (state_r == ST_RUN) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      carry_r <= dig_cout_s;
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      res_r   <= res_nxt_s;
    end
  end

  // Result registers update only on the final digit edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_diff         <= {WIDTH{1'b0}};
      carry_borrow_out <= 1'b0;
      overflow         <= 1'b0;
      zero             <= 1'b0;
    end else if (last_s) begin
      sum_diff         <= res_nxt_s;
      // For subtraction a carry out means no borrow.
      carry_borrow_out <= dig_cout_s ^ sub_r;
      overflow         <= ovf_s;
      zero             <= (res_nxt_s == {WIDTH{1'b0}});
    end
  end

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// Testbench for addsub_serial_nbit: one instance at WIDTH=8/DIGIT=2 and one
// at WIDTH=4/DIGIT=4, checked every cycle against an arithmetic model, plus
// directed cases with literal expectations.
module tb_addsub_serial_nbit;

  logic       clk;
  logic       rst_n;
  logic       start0, sel0, start1, sel1;
  logic [7:0] a0, b0;
  logic [3:0] a1, b1;
  logic       busy0, done0, cb0, ov0, z0;
  logic [7:0] sum0;
  logic       busy1, done1, cb1, ov1, z1;
  logic [3:0] sum1;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  addsub_serial_nbit #(.WIDTH(8), .DIGIT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .sel_add1_sub0(sel0), .busy(busy0), .done(done0), .sum_diff(sum0),
    .carry_borrow_out(cb0), .overflow(ov0), .zero(z0)
  );

  addsub_serial_nbit #(.WIDTH(4), .DIGIT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .sel_add1_sub0(sel1), .busy(busy1), .done(done1), .sum_diff(sum1),
    .carry_borrow_out(cb1), .overflow(ov1), .zero(z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Expected {zero, overflow, carry_borrow, result[7:0]} from plain arithmetic.
  function automatic logic [10:0] calc(input int w, input logic [7:0] av,
                                       input logic [7:0] bv, input logic add);
    int m, ai, bi, r;
    logic cb, ov, sa, sb, sr;
    m  = (1 << w) - 1;
    ai = int'(av) & m;
    bi = int'(bv) & m;
    if (add) begin
      r  = (ai + bi) & m;
      cb = ((ai + bi) > m);
    end else begin
      r  = (ai - bi) & m;
      cb = (ai < bi);
    end
    sa = ai[w-1];
    sb = bi[w-1];
    sr = r[w-1];
    ov = add ? ((sa == sb) && (sr != sa)) : ((sa != sb) && (sr != sa));
    return {(r == 0), ov, cb, r[7:0]};
  endfunction

  // Behavioural model: an op is accepted when not busy, results appear
  // exactly ND edges later, outputs hold otherwise.
  logic        m_busy [2];
  logic        m_done [2];
  int          m_rem  [2];
  logic [10:0] m_pend [2];
  logic [10:0] m_out  [2];
  int          nd     [2];
  int          wd     [2];
  initial begin
    nd[0] = 4; nd[1] = 1;
    wd[0] = 8; wd[1] = 4;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_rem[i]  <= 0;
        m_out[i]  <= 11'd0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_rem[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_out[i]  <= m_pend[i];
          end
          m_rem[i] <= m_rem[i] - 1;
        end else if ((i == 0) ? start0 : start1) begin
          m_pend[i] <= (i == 0) ? calc(wd[i], a0, b0, sel0)
                                : calc(wd[i], {4'd0, a1}, {4'd0, b1}, sel1);
          m_busy[i] <= 1'b1;
          m_rem[i]  <= nd[i];
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_w8", {21'd0, busy0, done0, z0, ov0, cb0, sum0},
          {21'd0, m_busy[0], m_done[0], m_out[0]});
      chk("cycle_w4", {21'd0, busy1, done1, z1, ov1, cb1, 4'd0, sum1},
          {21'd0, m_busy[1], m_done[1], m_out[1]});
    end
  end

  // Run one operation on instance inst; returns outputs and edges to done.
  task automatic do_op(input int inst, input logic [7:0] av, input logic [7:0] bv,
                       input logic add, output logic [10:0] res, output int lat);
    @(posedge clk); #1;
    if (inst == 0) begin start0 = 1'b1; a0 = av; b0 = bv; sel0 = add; end
    else begin start1 = 1'b1; a1 = av[3:0]; b1 = bv[3:0]; sel1 = add; end
    @(posedge clk); #1;
    // Disturb inputs after accept; the op in flight must not see this.
    start0 = 1'b0; start1 = 1'b0;
    a0 = 8'($urandom); b0 = 8'($urandom); sel0 = ~sel0;
    a1 = 4'($urandom); b1 = 4'($urandom); sel1 = ~sel1;
    lat = 0;
    res = 11'd0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((inst == 0) ? done0 : done1) begin
        lat = k;
        res = (inst == 0) ? {z0, ov0, cb0, sum0} : {z1, ov1, cb1, 4'd0, sum1};
        break;
      end
    end
  endtask

  logic [10:0] r;
  int          lat;

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; sel0 = 1'b1; a0 = 8'd0; b0 = 8'd0;
    start1 = 1'b0; sel1 = 1'b1; a1 = 4'd0; b1 = 4'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {27'd0, busy0, done0, cb0, ov0, z0}, 32'd0);
    chk("reset_sum", {24'd0, sum0}, 32'd0);
    #1 rst_n = 1'b1;

    // Directed cases with hand-computed literals (format {z,ov,cb,result}).
    do_op(0, 8'd200, 8'd100, 1'b1, r, lat);
    chk("add_200_100", {21'd0, r}, {21'd0, 1'b0, 1'b0, 1'b1, 8'd44});
    chk("lat_200_100", lat, 32'd4);
    do_op(0, 8'd10, 8'd4, 1'b0, r, lat);
    chk("sub_10_4", {21'd0, r}, {21'd0, 1'b0, 1'b0, 1'b0, 8'd6});
    do_op(0, 8'd3, 8'd7, 1'b0, r, lat);
    chk("sub_3_7", {21'd0, r}, {21'd0, 1'b0, 1'b0, 1'b1, 8'd252});
    do_op(0, 8'd127, 8'd1, 1'b1, r, lat);
    chk("add_127_1", {21'd0, r}, {21'd0, 1'b0, 1'b1, 1'b0, 8'd128});
    do_op(0, 8'd128, 8'd1, 1'b0, r, lat);
    chk("sub_128_1", {21'd0, r}, {21'd0, 1'b0, 1'b1, 1'b0, 8'd127});

    // Start during RUN is ignored; start held in the DONE cycle is accepted.
    @(posedge clk); #1;
    start0 = 1'b1; a0 = 8'd5; b0 = 8'd6; sel0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;              // E0
    @(posedge clk);                                // E1
    @(posedge clk); #1;                            // E2
    start0 = 1'b1; a0 = 8'd100; b0 = 8'd1; sel0 = 1'b0;
    @(posedge clk); #1 start0 = 1'b0;              // E3
    @(posedge clk);                                // E4
    @(negedge clk);
    chk("ignored_done", {31'd0, done0}, 32'd1);
    chk("ignored_sum", {24'd0, sum0}, 32'd11);
    start0 = 1'b1; a0 = 8'd1; b0 = 8'd2; sel0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) begin lat = k; break; end
    end
    chk("b2b_lat", lat, 32'd4);
    chk("b2b_sum", {24'd0, sum0}, 32'd3);

    // Reset mid-operation aborts it.
    @(posedge clk); #1;
    start0 = 1'b1; a0 = 8'd50; b0 = 8'd50; sel0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;              // E0
    @(posedge clk); #1 rst_n = 1'b0;               // E1
    @(posedge clk);                                // E2: reset sampled
    @(negedge clk);
    chk("midrst_outs", {27'd0, busy0, done0, cb0, ov0, z0}, 32'd0);
    chk("midrst_sum", {24'd0, sum0}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_nodone", {31'd0, done0}, 32'd0);
    end
    do_op(0, 8'd50, 8'd50, 1'b1, r, lat);
    chk("after_rst", {21'd0, r}, {21'd0, 1'b0, 1'b0, 1'b0, 8'd100});

    // Single-digit instance.
    do_op(1, 8'd4, 8'd4, 1'b0, r, lat);
    chk("w4_sub_4_4", {21'd0, r}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});
    chk("w4_lat_sub", lat, 32'd1);
    do_op(1, 8'd10, 8'd6, 1'b1, r, lat);
    chk("w4_add_10_6", {21'd0, r}, {21'd0, 1'b1, 1'b0, 1'b1, 8'd0});
    chk("w4_lat_add", lat, 32'd1);

    // Randomized traffic, including start while busy and rare resets.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      start0 = ($urandom_range(0, 2) == 0);
      a0 = 8'($urandom); b0 = 8'($urandom); sel0 = 1'($urandom);
      start1 = ($urandom_range(0, 2) == 0);
      a1 = 4'($urandom); b1 = 4'($urandom); sel1 = 1'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
